dmem_burst_reader: RTL and testbench
====================================

Name: dmem_burst_reader

Overview:
- Read-side counterpart of the 16-bit load/increment address registers: owns an internal address counter and streams a burst of data-memory words out over a valid/ready interface.
- Sits between the data memory's synchronous read port and any consumer, e.g. the writeback or DMA path.
- Issues reads at a fixed memory latency and buffers returned data, so consumer backpressure never drops a word.

Parameters:
- ADDR_W, 16, address and length width.
- DATA_W, 16, memory word width.
- MEM_LAT, 2, cycles from mem_rd_en high to mem_rdata valid (1..4).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle burst request; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address, captured on accepted start.
- length  input  ADDR_W  word count, captured on accepted start; 0 is legal.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the burst is complete.
- mem_addr  output  ADDR_W  read address to memory.
- mem_rd_en  output  1  read strobe; one word per high cycle.
- mem_rdata  input  DATA_W  read data, valid MEM_LAT cycles after the strobe.
- out_data  output  DATA_W  head-of-buffer word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.

Behaviour:
- Reset (reset=0, any time, asynchronous): state IDLE. busy, done, mem_rd_en and out_valid are 0; mem_addr, out_data and all counters are 0. The buffer is emptied.
- Reset mid-burst: the burst is abandoned. Late mem_rdata returns are ignored because the latency pipe is cleared.
- States:
  - IDLE --start--> ISSUE if length!=0.
  - IDLE --start--> DONE if length==0.
  - ISSUE --last read issued--> DRAIN.
  - DRAIN --in-flight==0 and buffer empty--> DONE.
  - DONE --> IDLE, after exactly one cycle.
- start outside IDLE is ignored.
- Address counter:
  - Loaded with base_addr on start.
  - Increments by 1 on each issued read; mem_addr shows the counter.
  - Wraps 0xFFFF -> 0x0000 with no error.
- Remaining counter: loaded with length; decrements per issued read.
- Latency pipe: a MEM_LAT-deep shift register of valid bits. A word is pushed into the buffer when the pipe tail is 1.
- Buffer: FIFO of depth MEM_LAT+1 with first-word-fall-through. out_valid = not empty.
- Credit rule: mem_rd_en=1 only in ISSUE, and only when (in-flight + buffer occupancy) < MEM_LAT+1. This guarantees no overflow.
- Throughput: with out_ready held at 1, one word per cycle is sustained. The first out_valid appears MEM_LAT+1 cycles after the start edge.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- Word order equals address order.
- done is asserted only after the last word is accepted by the consumer. busy falls in the same cycle that done rises.
- Length 0: done pulses on the cycle after start. No mem_rd_en, no out_valid.

Optional Feature:
- Macro DMEM_RD_ABORT_EN adds input abort (1 bit) and output aborted (1 bit).
- With the macro: abort=1 in ISSUE or DRAIN stops issuing immediately, flushes the buffer, and drops any words still in flight. The block goes to DONE once in-flight reaches 0. done and aborted pulse together. out_valid is 0 from the cycle after abort.
- Without the macro: no abort or aborted ports exist, and every burst runs to completion.

Decomposition:
- Shared package dmem_rd_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - the default widths ADDR_W and DATA_W;
  - the MEM_LAT bounds constants.
- One natural sub-module: dmem_rd_fifo, a parameterised first-word-fall-through FIFO with count output.
- Counters and the latency pipe stay in the top level.

Test Plan:
- Basic burst: base_addr=0x0010, length=4, out_ready=1 -> mem_addr 0x10..0x13 on 4 consecutive cycles; out_data in order; done 1 cycle after the 4th accept.
- Backpressure: length=8, out_ready toggles 1010... -> no word lost or duplicated; occupancy never exceeds MEM_LAT+1; mem_rd_en stalls while credit is exhausted.
- Wrap: base_addr=0xFFFE, length=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Length 0: start with length=0 -> done the next cycle; mem_rd_en and out_valid stay 0; busy high for 1 cycle only.
- Reset mid-burst: reset low at word 3 of 10 -> all outputs 0 asynchronously; after release, a new burst base_addr=0x0100, length=2 is clean.
- Start while busy (and abort, if enabled): start pulse during ISSUE is ignored. With DMEM_RD_ABORT_EN, abort at word 2 of 6 -> done and aborted pulse once, no further out_valid.

Source files
------------

// File: rtl/dmem_rd_pkg.sv
// Shared types and constants for the data-memory burst reader.
// Holds the FSM state encoding, default widths and the supported read-latency range.
package dmem_rd_pkg;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 16;
   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bits needed to hold any value in 0..max_val.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dmem_burst_reader_if.sv
// Control, memory-read and stream-out signals of the burst reader.
// Macro DMEM_RD_ABORT_EN adds the abort/aborted pair.
interface dmem_burst_reader_if
   import dmem_rd_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] length;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
`ifdef DMEM_RD_ABORT_EN
   logic              abort;
   logic              aborted;

   modport slave (
      input  start, base_addr, length, mem_rdata, out_ready, abort,
      output busy, done, mem_addr, mem_rd_en, out_data, out_valid, aborted
   );

   modport master (
      output start, base_addr, length, mem_rdata, out_ready, abort,
      input  busy, done, mem_addr, mem_rd_en, out_data, out_valid, aborted
   );
`else
   modport slave (
      input  start, base_addr, length, mem_rdata, out_ready,
      output busy, done, mem_addr, mem_rd_en, out_data, out_valid
   );

   modport master (
      output start, base_addr, length, mem_rdata, out_ready,
      input  busy, done, mem_addr, mem_rd_en, out_data, out_valid
   );
`endif

endinterface

// File: rtl/dmem_rd_fifo.sv
// First-word-fall-through FIFO with occupancy output and synchronous flush.
// Head word is presented combinationally; output reads 0 while empty.
module dmem_rd_fifo
   import dmem_rd_pkg::*;
#(
   parameter int  WIDTH = DEF_DATA_W,
   parameter int  DEPTH = 3,
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_pop = i_pop && (r_count != '0);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
      end
   end

   // NOTE: storage is not reset; the count gates the output, so stale contents are never seen.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_valid = (r_count != '0);
   assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/dmem_burst_reader.sv
// Streams a burst of data-memory words from an auto-incrementing address over valid/ready.
// Optional abort support is enabled by defining DMEM_RD_ABORT_EN.
module dmem_burst_reader
   import dmem_rd_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = 2
) (
   input logic                clk,
   input logic                reset,
   dmem_burst_reader_if.slave bus
);

   localparam int DEPTH = MEM_LAT + 1;
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int OCC_W = CNT_W + 1;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_rem;
   logic [MEM_LAT-1:0] r_pipe;
   logic [CNT_W-1:0]  r_inflight;
   logic              r_abort_q;

   logic              w_abort;
   logic              w_issue;
   logic              w_tail;
   logic              w_push;
   logic              w_pop;
   logic              w_valid;
   logic              w_credit;
   logic              w_drained;
   logic [CNT_W-1:0]  w_count;
   logic [OCC_W-1:0]  w_occ;
   logic [DATA_W-1:0] w_fifo_data;

`ifdef DMEM_RD_ABORT_EN
   assign w_abort     = bus.abort && ((r_state == ISSUE) || (r_state == DRAIN));
   assign bus.aborted = (r_state == DONE) && r_abort_q;
`else
   assign w_abort = 1'b0;
`endif

   assign w_tail = r_pipe[MEM_LAT-1];
   assign w_pop  = w_valid && bus.out_ready;

   // A word popped this cycle frees its slot now, which is what sustains one word per cycle.
   assign w_occ     = OCC_W'(r_inflight) + OCC_W'(w_count) - OCC_W'(w_pop);
   assign w_credit  = (w_occ < OCC_W'(DEPTH));
   assign w_issue   = (r_state == ISSUE) && w_credit && !w_abort;
   assign w_push    = w_tail && !r_abort_q && !w_abort;
   assign w_drained = (w_count == '0) || ((w_count == CNT_W'(1)) && w_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // NOTE: the default assignment up front keeps every path driven, so no latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = (bus.length == '0) ? DONE : ISSUE;
         ISSUE:   if (w_abort || (w_issue && (r_rem == ADDR_W'(1)))) w_next = DRAIN;
         DRAIN:   if ((r_inflight == '0) && (w_abort || r_abort_q || w_drained)) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr     <= '0;
         r_rem      <= '0;
         r_pipe     <= '0;
         r_inflight <= '0;
         r_abort_q  <= 1'b0;
      end else begin
         if ((r_state == IDLE) && bus.start) begin
            r_addr <= bus.base_addr;
            r_rem  <= bus.length;
         end else if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rem  <= r_rem - ADDR_W'(1);
         end
         r_pipe     <= (r_pipe << 1) | MEM_LAT'(w_issue);
         r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_tail);
         // Words returning after an abort still drain the in-flight count but are discarded.
         if (r_state == DONE) r_abort_q <= 1'b0;
         else if (w_abort)    r_abort_q <= 1'b1;
      end
   end

   dmem_rd_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (w_abort),
      .i_push  (w_push),
      .i_data  (bus.mem_rdata),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_valid (w_valid),
      .o_count (w_count)
   );

   assign bus.busy      = ((r_state == IDLE) && bus.start) || (r_state == ISSUE) || (r_state == DRAIN);
   assign bus.done      = (r_state == DONE);
   assign bus.mem_addr  = r_addr;
   assign bus.mem_rd_en = w_issue;
   assign bus.out_data  = w_fifo_data;
   assign bus.out_valid = w_valid;

endmodule

// File: tb/tb_dmem_burst_reader.sv
// Randomised self-checking bench for dmem_burst_reader against a transaction-level model.
// Abort scenarios are exercised when DMEM_RD_ABORT_EN is defined.
module tb_dmem_burst_reader;

   localparam int MEM_LAT = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   dmem_burst_reader_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   dmem_burst_reader #(
      .ADDR_W  (16),
      .DATA_W  (16),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory contents are a fixed scramble of the address.
   function automatic logic [15:0] dat(input logic [15:0] a);
      return (a * 16'd40503) ^ 16'h5A3C;
   endfunction

   // Synchronous-read memory: the address presented in a cycle returns MEM_LAT cycles later.
   logic [15:0] q_addr [MEM_LAT];
   always @(posedge clk) begin
      q_addr[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LAT; i++) q_addr[i] <= q_addr[i-1];
   end
   assign bus.mem_rdata = dat(q_addr[MEM_LAT-1]);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic rdy_of(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 2) == 1;
      return ($urandom % 4) != 0;
   endfunction

   // One burst: drives start, consumer readiness and optional abort/reset, then
   // compares observed traffic with what the burst rules require.
   task automatic run_burst(input logic [15:0] base, input logic [15:0] len, input int rmode,
                            input int restart_cyc, input int abort_acc, input int reset_acc);
      int          n_iss, n_acc, first_valid, done_cyc, done_cnt, last_acc, max_out;
      int          abort_cyc, valid_after_abort, aborted_cnt, aborted_with_done;
      logic        busy_at_done, rst_hit;
      logic [15:0] exp_addr;
      n_iss = 0; n_acc = 0; first_valid = -1; done_cyc = -1; done_cnt = 0;
      last_acc = -1; max_out = 0; abort_cyc = -1; valid_after_abort = 0;
      aborted_cnt = 0; aborted_with_done = 0; busy_at_done = 1'b0; rst_hit = 1'b0;
      exp_addr = base;

      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.length    = len;
      bus.out_ready = rdy_of(rmode, 0);
      @(negedge clk);
      check("busy_on_start", bus.busy, 1);

      for (int cyc = 1; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         bus.start     = (cyc == restart_cyc);
         bus.base_addr = 16'hBEEF;
         bus.length    = 16'd5;
         bus.out_ready = rdy_of(rmode, cyc);
`ifdef DMEM_RD_ABORT_EN
         bus.abort = (abort_acc >= 0) && (abort_cyc < 0) && (n_acc == abort_acc);
         if (bus.abort) abort_cyc = cyc;
`endif
         if ((reset_acc >= 0) && (n_acc == reset_acc)) begin
            reset = 1'b0;
            #1;
            check("rst_ctl", {bus.busy, bus.done, bus.mem_rd_en, bus.out_valid}, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
            check("rst_out_data", bus.out_data, 0);
            rst_hit = 1'b1;
            break;
         end
         @(negedge clk);
         if (bus.mem_rd_en) begin
            check("mem_addr", bus.mem_addr, exp_addr);
            exp_addr = exp_addr + 16'd1;
            n_iss++;
         end
         if (bus.out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if ((abort_cyc >= 0) && (cyc > abort_cyc)) valid_after_abort++;
         end
         if (bus.out_valid && bus.out_ready) begin
            check("out_data", bus.out_data, dat(base + 16'(n_acc)));
            n_acc++;
            last_acc = cyc;
         end
         if ((n_iss - n_acc) > max_out) max_out = n_iss - n_acc;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            busy_at_done = busy_at_done | bus.busy;
         end
`ifdef DMEM_RD_ABORT_EN
         if (bus.aborted) aborted_cnt++;
         if (bus.aborted && bus.done) aborted_with_done++;
`endif
         if ((done_cyc >= 0) && (cyc == done_cyc + 1)) begin
            check("idle_after_done", {bus.busy, bus.done, bus.out_valid, bus.mem_rd_en}, 0);
            break;
         end
      end
`ifdef DMEM_RD_ABORT_EN
      bus.abort = 1'b0;
`endif
      bus.start = 1'b0;

      if (rst_hit) begin
         repeat (2) @(posedge clk);
         #1 reset = 1'b1;
         @(negedge clk);
         check("post_rst_idle", {bus.busy, bus.done, bus.out_valid, bus.mem_rd_en}, 0);
         return;
      end

      check("done_seen", done_cyc >= 0, 1);
      check("done_once", done_cnt, 1);
      check("busy_at_done", busy_at_done, 0);
      check("max_outstanding", max_out <= MEM_LAT + 1, 1);
      if (abort_acc < 0) begin
         check("issued", n_iss, len);
         check("accepted", n_acc, len);
         check("aborted_idle", aborted_cnt, 0);
         if (len == 0) begin
            check("len0_done_cyc", done_cyc, 1);
            check("len0_no_valid", first_valid, -1);
         end else begin
            check("done_after_last", done_cyc, last_acc + 1);
         end
         if ((rmode == 0) && (len != 0)) begin
            check("first_valid_lat", first_valid, MEM_LAT + 2);
            check("full_rate_done", done_cyc, MEM_LAT + 2 + int'(len));
         end
      end else begin
         check("abort_issued_le", n_iss <= int'(len), 1);
         check("abort_no_valid", valid_after_abort, 0);
         check("aborted_once", aborted_cnt, 1);
         check("aborted_with_done", aborted_with_done, 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset         = 1'b0;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.length    = '0;
      bus.out_ready = 1'b0;
`ifdef DMEM_RD_ABORT_EN
      bus.abort     = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("reset_ctl", {bus.busy, bus.done, bus.mem_rd_en, bus.out_valid}, 0);
      check("reset_mem_addr", bus.mem_addr, 0);
      check("reset_out_data", bus.out_data, 0);
      @(posedge clk); #1 reset = 1'b1;

      run_burst(16'h0010, 16'd4, 0, -1, -1, -1);   // basic
      run_burst(16'h0040, 16'd8, 1, -1, -1, -1);   // alternating backpressure
      run_burst(16'hFFFE, 16'd4, 0, -1, -1, -1);   // address wrap
      run_burst(16'h0123, 16'd0, 0, -1, -1, -1);   // zero length
      run_burst(16'h0200, 16'd10, 0, -1, -1, 3);   // reset mid-burst
      run_burst(16'h0100, 16'd2, 0, -1, -1, -1);   // clean burst after reset
      run_burst(16'h0300, 16'd8, 0, 2, -1, -1);    // start while busy ignored
`ifdef DMEM_RD_ABORT_EN
      run_burst(16'h0400, 16'd6, 0, -1, 2, -1);    // abort at word 2
      run_burst(16'h0500, 16'd9, 1, -1, 1, -1);    // abort under backpressure
`endif
      for (int k = 0; k < 8; k++) begin
         run_burst(16'($urandom), 16'($urandom_range(0, 12)), 2, -1, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
